// File: rtl/fft_frame_sequencer_if.sv
// Source-beat and stage-0 streaming bus of the FFT front-end sequencer.
// Lanes carry two's-complement samples; the slave side is the sequencer.
interface fft_frame_sequencer_if #(
  parameter int NUM_LANES = 16,
  parameter int VEC_W     = 9
);
  logic                            s_valid;
  logic                            s_ready;
  logic                            s_last;
  logic [NUM_LANES-1:0][VEC_W-1:0] s_din_R;
  logic [NUM_LANES-1:0][VEC_W-1:0] s_din_Q;
  logic                            fft_valid;
  logic [NUM_LANES-1:0][VEC_W-1:0] fft_din_R;
  logic [NUM_LANES-1:0][VEC_W-1:0] fft_din_Q;
  logic                            valid_mod1;

  modport master (
    output s_valid, s_last, s_din_R, s_din_Q, valid_mod1,
    input  s_ready, fft_valid, fft_din_R, fft_din_Q
  );
  modport slave (
    input  s_valid, s_last, s_din_R, s_din_Q, valid_mod1,
    output s_ready, fft_valid, fft_din_R, fft_din_Q
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frames 16-lane input beats into FFT frames, feeds stage 0 through one register
// stage and tracks frames in flight by counting the stage's output strobe.
module fft_seq_lane #(
  parameter int VEC_W = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ld,
  input  logic [VEC_W-1:0] d_r,
  input  logic [VEC_W-1:0] d_q,
  output logic [VEC_W-1:0] q_r,
  output logic [VEC_W-1:0] q_q
);
  always_ff @(posedge clk) begin
    if (rstn) begin
      q_r <= '0;
      q_q <= '0;
    end else if (ld) begin
      q_r <= d_r;
      q_q <= d_q;
    end
  end
endmodule

module fft_frame_sequencer #(
  parameter  int BEATS_PER_FRAME = 32,
  parameter  int MAX_INFLIGHT    = 2,
  parameter  int TIMEOUT         = 1023,
  parameter  int NUM_LANES       = 16,
  parameter  int VEC_W           = 9,
  localparam int IW              = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 clear_err,
  fft_frame_sequencer_if.slave bus,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic [IW-1:0]        inflight,
  output logic                 busy,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic                 err_overrun
);
  localparam int CW = $clog2(BEATS_PER_FRAME);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, ERR} state_t;

  state_t        state;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [TW-1:0] to_cnt;
  logic          ready, fv_q;
  logic          accept, first_acc, out_beat, last_out, active;
  logic          len_det, ovr_det, to_det;
  logic [NUM_LANES-1:0][VEC_W-1:0] din_r, din_q;

  // A partial frame may always finish; a new frame needs a free in-flight slot.
  always_comb begin
    ready = 1'b0;
    case (state)
      RUN:     ready = (in_cnt != '0) || (inflight < IW'(MAX_INFLIGHT));
      FLUSH:   ready = (in_cnt != '0);
      default: ready = 1'b0;
    endcase
  end

  assign accept    = bus.s_valid & ready;
  assign first_acc = accept & (in_cnt == '0);
  assign out_beat  = bus.valid_mod1 & (inflight != '0);
  assign last_out  = out_beat & (out_cnt == LAST);
  assign active    = (state == RUN) || (state == FLUSH);
  assign len_det   = accept & (bus.s_last != (in_cnt == LAST));
  assign ovr_det   = bus.valid_mod1 & (inflight == '0);
  assign to_det    = active & (inflight != '0) & ~bus.valid_mod1 &
                     (to_cnt == TW'(TIMEOUT - 1));
  assign busy      = (state != IDLE) || (inflight != '0);

  assign bus.s_ready   = ready;
  assign bus.fft_valid = fv_q;
  assign bus.fft_din_R = din_r;
  assign bus.fft_din_Q = din_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fft_seq_lane #(.VEC_W(VEC_W)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .ld   (accept),
      .d_r  (bus.s_din_R[i]),
      .d_q  (bus.s_din_Q[i]),
      .q_r  (din_r[i]),
      .q_q  (din_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      to_cnt      <= '0;
      inflight    <= '0;
      fv_q        <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      fv_q        <= accept;
      frame_start <= first_acc;
      frame_done  <= last_out;
      if (clear_err) begin
        in_cnt      <= '0;
        out_cnt     <= '0;
        to_cnt      <= '0;
        inflight    <= '0;
        err_len     <= 1'b0;
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
        if (state == ERR) state <= IDLE;
      end else begin
        if (accept)   in_cnt  <= (in_cnt == LAST)  ? '0 : in_cnt + CW'(1);
        if (out_beat) out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + CW'(1);
        // Slot is reserved at frame start, released on the frame's last output beat.
        inflight <= inflight + IW'(first_acc) - IW'(last_out);
        if (!active || inflight == '0 || bus.valid_mod1) to_cnt <= '0;
        else                                             to_cnt <= to_cnt + TW'(1);
        err_len     <= err_len | len_det;
        err_overrun <= err_overrun | ovr_det;
        err_timeout <= err_timeout | to_det;
        case (state)
          IDLE:    if (enable) state <= RUN;
          RUN:     if (to_det) state <= ERR;
                   else if (!enable) state <= FLUSH;
          FLUSH:   if (to_det) state <= ERR;
                   else if (in_cnt == '0 && inflight == '0) state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end
endmodule
